// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared register-file write bus types and widths
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // Common shape of the writeback, MDU-result and regfile write buses
  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } rf_wr_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// rtl/rf_write_arbiter_if.sv - writeback, MDU and regfile write-port bundle
interface rf_write_arbiter_if #(
  parameter int XLEN = riscv_pkg::XLEN
) ();
  import riscv_pkg::*;

  logic                  wb_we_i;
  logic [REG_ADDR_W-1:0] wb_sel_rd_i;
  logic [XLEN-1:0]       wb_data_i;
  logic                  issue_i;
  logic [REG_ADDR_W-1:0] issue_rd_i;
  logic                  mdu_valid_i;
  logic [REG_ADDR_W-1:0] mdu_rd_i;
  logic [XLEN-1:0]       mdu_data_i;
  logic                  mdu_ready_o;
  logic                  rf_we_o;
  logic [REG_ADDR_W-1:0] rf_sel_rd_o;
  logic [XLEN-1:0]       rf_data_o;
  logic [31:0]           busy_o;
  logic                  stall_o;

  modport master (
    output wb_we_i, wb_sel_rd_i, wb_data_i,
    output issue_i, issue_rd_i,
    output mdu_valid_i, mdu_rd_i, mdu_data_i,
    input  mdu_ready_o, rf_we_o, rf_sel_rd_o, rf_data_o, busy_o, stall_o
  );

  modport slave (
    input  wb_we_i, wb_sel_rd_i, wb_data_i,
    input  issue_i, issue_rd_i,
    input  mdu_valid_i, mdu_rd_i, mdu_data_i,
    output mdu_ready_o, rf_we_o, rf_sel_rd_o, rf_data_o, busy_o, stall_o
  );

endinterface

// File: rtl/rf_write_arbiter_hold.sv
// rtl/rf_write_arbiter_hold.sv - one-entry valid/ready holding register for MDU results
module rf_wr_hold
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  rf_wr_t                in_i,
  output logic                  in_ready_o,
  input  logic                  drain_i,
  output logic                  valid_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [XLEN-1:0]       data_o
);

  logic                  valid_q, valid_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       data_q, data_d;

  // Ready is taken from the flop, so a slot drained this edge refills one edge later
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (valid_q) begin
      if (drain_i) valid_d = 1'b0;
    end else if (in_i.we) begin
      valid_d = 1'b1;
      rd_d    = in_i.rd;
      data_d  = in_i.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign in_ready_o = !valid_q;
  assign valid_o    = valid_q;
  assign rd_o       = rd_q;
  assign data_o     = data_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - regfile write-port arbiter: writeback first, MDU drains on idle cycles
module rf_write_arbiter #(
  parameter int XLEN         = riscv_pkg::XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  rf_write_arbiter_if.slave bus
);
  import riscv_pkg::*;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  rf_wr_t                mdu_in;
  logic                  hold_valid;
  logic                  hold_drain;
  logic [REG_ADDR_W-1:0] hold_rd;
  logic [XLEN-1:0]       hold_data;

  rf_wr_t                rf_d, rf_q;
  logic [CNT_W-1:0]      starve_d, starve_q;
  logic                  stall_d, stall_q;
  logic [31:0]           busy_d, busy_q;

  assign mdu_in = '{we: bus.mdu_valid_i, rd: bus.mdu_rd_i, data: bus.mdu_data_i};

  rf_wr_hold u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_i       (mdu_in),
    .in_ready_o (bus.mdu_ready_o),
    .drain_i    (hold_drain),
    .valid_o    (hold_valid),
    .rd_o       (hold_rd),
    .data_o     (hold_data)
  );

  // Writes to x0 are squashed to an all-zero bus, but a held x0 result still drains
  always_comb begin
    hold_drain = hold_valid && !bus.wb_we_i;
    rf_d       = '0;
    if (bus.wb_we_i) begin
      if (bus.wb_sel_rd_i != '0)
        rf_d = '{we: 1'b1, rd: bus.wb_sel_rd_i, data: bus.wb_data_i};
    end else if (hold_valid && hold_rd != '0) begin
      rf_d = '{we: 1'b1, rd: hold_rd, data: hold_data};
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (hold_drain)
      starve_d = '0;
    else if (hold_valid && bus.wb_we_i && starve_q != LIMIT)
      starve_d = starve_q + 1'b1;
    // Stays high while saturated, so a missed bubble re-requests next cycle
    stall_d = (starve_d == LIMIT);
  end

  always_comb begin
    busy_d = busy_q;
    if (hold_drain) busy_d[hold_rd] = 1'b0;
    if (bus.issue_i) busy_d[bus.issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q     <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      busy_q   <= '0;
    end else begin
      rf_q     <= rf_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.rf_we_o     = rf_q.we;
  assign bus.rf_sel_rd_o = rf_q.rd;
  assign bus.rf_data_o   = rf_q.data;
  assign bus.busy_o      = busy_q;
  assign bus.stall_o     = stall_q;

endmodule
